inst_fetch_unit: RTL and testbench

- Instruction issue front-end. Drives the IR word into the combinational execute unit (opcodes 00000-01011).
- Fetches 32-bit instructions from a synchronous instruction ROM over the address range [start_addr, end_addr].
- Buffers fetched words in a small prefetch FIFO and presents them one per handshake on a valid/ready interface.
- Is the initiator/producer side of the IR interface; the execute stage is the consumer.

---
 rtl/inst_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end.
//
// Walks the instruction ROM from start_addr to end_addr (inclusive, wrapping
// modulo 2^ADDR_W) and queues the returned words in a DEPTH-entry prefetch
// FIFO. The FIFO head goes to the execute stage over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a run (accepted only when idle)
//   start_addr, end_addr  run address range, sampled on an accepted start
//   halt_req              abort the run, flush the FIFO, return to idle
//   imem_en, imem_addr    ROM read strobe / address
//   imem_rdata            ROM data, valid one cycle after imem_en
//   ir_out, ir_valid      FIFO head word and its valid flag
//   ir_ready              consumer accepts ir_out this cycle
//   pc                    next address to fetch
//   busy                  run in progress (fetching or draining)
//   done                  one-cycle pulse when the last word of a run is accepted
module inst_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              halt_req,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              inflight_q, inflight_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       fifo_q [DEPTH];
  logic [31:0]       fifo_d [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CntW-1:0] occupancy;

  // Datapath handshakes and outputs.
  always_comb begin
    // Slots already promised to a read in flight count as occupied, so the
    // FIFO can never overflow when the data lands.
    occupancy = count_q + CntW'(inflight_q);
    issue     = (state_q == StFetch) && !halt_req && (occupancy < CntW'(DEPTH));
    // Data returning during a halt belongs to the aborted run.
    push      = inflight_q && !halt_req;
    ir_valid  = (count_q != '0);
    pop       = ir_valid && ir_ready;
    ir_out    = fifo_q[rd_ptr_q];
    imem_en   = issue;
    imem_addr = pc_q;
    pc        = pc_q;
    busy      = (state_q != StIdle);
    // Last word of the run: nothing else queued or on its way back.
    done      = (state_q == StDrain) && !halt_req && pop && !inflight_q &&
                (count_q == CntW'(1));
  end

  // FIFO bookkeeping.
  always_comb begin
    fifo_d     = fifo_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = issue;

    if (push) begin
      fifo_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (halt_req && (state_q != StIdle)) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
    end
  end

  // Run control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;

    unique case (state_q)
      StIdle: begin
        // A simultaneous halt request cancels the start.
        if (start && !halt_req) begin
          state_d = StFetch;
          pc_d    = start_addr;
          end_d   = end_addr;
        end
      end
      StFetch: begin
        if (halt_req) begin
          state_d = StIdle;
        end else if (issue) begin
          pc_d = pc_q + ADDR_W'(1);
          if (pc_q == end_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (halt_req || done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      end_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      end_q      <= end_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit. Each accepted start queues the words
// and addresses the run must produce; monitors pop and compare them.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [7:0]  end_addr = '0;
  logic        halt_req = 1'b0;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [7:0]  pc;
  logic        busy;
  logic        done;

  inst_fetch_unit #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .halt_req  (halt_req),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model.
  logic [31:0] rom [256];
  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  addr_q [$];
  int pop_cnt = 0;
  int done_cnt = 0;
  bit rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a run produces rom[s], rom[s+1], ... up to e, wrapping mod 256.
  task automatic start_run(input logic [7:0] s, input logic [7:0] e);
    logic [7:0] a;
    a = s;
    forever begin
      exp_q.push_back(rom[a]);
      addr_q.push_back(a);
      if (a == e) break;
      a = a + 8'd1;
    end
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic flush();
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    bad("wait_idle_timeout", {31'd0, busy});
  endtask

  // Monitor: read addresses, presented words, and the done pulse.
  always @(negedge clk) begin
    logic exp_done;
    if (rst_n) begin
      exp_done = 1'b0;
      if (imem_en) begin
        if (addr_q.size() == 0) bad("unexpected_read", {24'd0, imem_addr});
        else chk("imem_addr", {24'd0, imem_addr}, {24'd0, addr_q.pop_front()});
      end
      if (ir_valid) begin
        if (exp_q.size() == 0) begin
          bad("unexpected_ir", ir_out);
        end else begin
          chk("ir_out", ir_out, exp_q[0]);
          if (ir_ready) begin
            exp_done = (exp_q.size() == 1) && !halt_req;
            void'(exp_q.pop_front());
            pop_cnt++;
          end
        end
      end
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if (done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      ir_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int reads;
    int d0;
    int p0;
    logic [7:0] s;
    int len;

    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[8'h10] = 32'h08400005;
    rom[8'h11] = 32'h10842000;
    rom[8'h12] = 32'h18A40000;
    rom[8'h13] = 32'h20C60003;

    // Reset values.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_ir_out", ir_out, 32'd0);
    chk("rst_flags", {28'd0, imem_en, ir_valid, busy, done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic run: 2-cycle latency, 4 back-to-back words, done on the 4th.
    ir_ready = 1'b1;
    d0 = done_cnt;
    start_run(8'h10, 8'h13);
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      if (n <= 5) chk("basic_valid", {31'd0, ir_valid}, {31'd0, (n >= 2)});
      if (n == 5) chk("basic_done", {31'd0, done}, 32'd1);
      if (n == 6) chk("basic_busy_fall", {31'd0, busy}, 32'd0);
    end
    chk("basic_done_cnt", done_cnt - d0, 1);
    chk("basic_drained", exp_q.size(), 0);

    // Backpressure, then a start pulse while busy.
    step();
    ir_ready = 1'b0;
    p0 = pop_cnt;
    reads = 0;
    start_run(8'h10, 8'h13);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (imem_en) reads++;
      if (n == 5) begin
        chk("bp_imem_en_off", {31'd0, imem_en}, 32'd0);
        chk("bp_head", ir_out, 32'h08400005);
        chk("bp_valid", {31'd0, ir_valid}, 32'd1);
      end
    end
    chk("bp_reads", reads, 4);
    step();
    start_addr = 8'h80;
    end_addr   = 8'h90;
    start      = 1'b1;
    step();
    start      = 1'b0;
    @(negedge clk);
    chk("busy_start_pc", {24'd0, pc}, 32'h14);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    step();
    ir_ready = 1'b1;
    wait_idle(20);
    chk("bp_pops", pop_cnt - p0, 4);
    chk("bp_drained", exp_q.size(), 0);

    // Wrapped range.
    step();
    d0 = done_cnt;
    p0 = pop_cnt;
    start_run(8'hFE, 8'h01);
    wait_idle(30);
    chk("wrap_pops", pop_cnt - p0, 4);
    chk("wrap_done", done_cnt - d0, 1);
    chk("wrap_reads_left", addr_q.size(), 0);

    // Single-instruction run.
    step();
    d0 = done_cnt;
    p0 = pop_cnt;
    start_run(8'h20, 8'h20);
    wait_idle(20);
    chk("single_pops", pop_cnt - p0, 1);
    chk("single_done", done_cnt - d0, 1);
    chk("single_reads_left", addr_q.size(), 0);

    // Halt mid-run.
    step();
    d0 = done_cnt;
    start_run(8'h00, 8'h0F);
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    flush();
    @(negedge clk);
    chk("halt_valid", {31'd0, ir_valid}, 32'd0);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    for (int n = 0; n < 8; n++) @(negedge clk);
    chk("halt_no_done", done_cnt - d0, 0);

    // start together with halt_req in idle.
    step();
    start_addr = 8'h30;
    end_addr   = 8'h33;
    start      = 1'b1;
    halt_req   = 1'b1;
    step();
    start      = 1'b0;
    halt_req   = 1'b0;
    @(negedge clk);
    chk("prio_busy", {31'd0, busy}, 32'd0);
    chk("prio_imem_en", {31'd0, imem_en}, 32'd0);

    // Asynchronous reset mid-fetch.
    step();
    ir_ready = 1'b0;
    start_run(8'h40, 8'h4F);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", {24'd0, pc}, 32'd0);
    chk("arst_imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("arst_ir_out", ir_out, 32'd0);
    chk("arst_flags", {28'd0, imem_en, ir_valid, busy, done}, 32'd0);
    flush();
    step();
    rst_n = 1'b1;
    step();

    // Randomized runs with random backpressure and occasional halts.
    rand_rdy = 1;
    for (int r = 0; r < 12; r++) begin
      step();
      s   = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 24);
      d0  = done_cnt;
      start_run(s, s + 8'(len - 1));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < $urandom_range(0, len); k++) step();
        if (busy) begin
          halt_req = 1'b1;
          step();
          halt_req = 1'b0;
          flush();
          @(negedge clk);
          chk("rand_halt_busy", {31'd0, busy}, 32'd0);
        end else begin
          chk("rand_early_done", done_cnt - d0, 1);
        end
      end else begin
        wait_idle(400);
        chk("rand_done", done_cnt - d0, 1);
        chk("rand_drained", exp_q.size(), 0);
      end
    end
    rand_rdy = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
